herculesae_vx_sha256_msgsched: RTL and testbench
================================================

# herculesae_vx_sha256_msgsched

Sequential SHA-256 message-schedule engine that produces the per-round W[t]+K[t] word consumed as the round-input operand of the vexecute SHA-256 hash-round datapath. It accepts one 512-bit message block. It then streams 64 schedule words, t = 0..63, over a valid/ready interface, one word per accepted beat. The message expansion W[16..63] is computed internally with a 16-word sliding window.

## Interface
- Parameters: none; the SHA-256 geometry (16-word window, 64 rounds, 32-bit words) is fixed.
- clk  in  1  single clock, rising edge
- reset  in  1  reset is asynchronous and active-high
- blk_valid  in  1  message block offered
- blk_ready  out  1  engine accepts block this cycle
- blk_data  in  512  message block; W[i] = blk_data[32*i+31:32*i], i = 0..15
- flush  in  1  synchronous abort of the current block
- wk_valid  out  1  schedule word valid
- wk_ready  in  1  consumer accepts schedule word
- wk_data  out  32  W[t]+K[t] mod 2^32; forced 0 when wk_valid = 0
- wk_idx  out  6  round index t of the current word
- wk_last  out  1  wk_valid & (wk_idx == 63)
- busy  out  1  state != IDLE

## Operation
- States: IDLE and RUN. Registers: window w[0..15] of 32 bits each, 6-bit counter t, and state.
- IDLE: blk_ready = ~flush.
  - A block handshake loads w[i] = W[i], sets t = 0 and moves to RUN.
- RUN: wk_valid = 1 and wk_data = w[0] + K[t].
- On a wk handshake:
  - The window shifts: w[i] <= w[i+1] for i = 0..14.
  - w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32.
  - t increments.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- The handshake at t = 63 ends the block:
  - If a new block handshakes in the same cycle, the engine reloads with t = 0 and stays in RUN.
  - Otherwise it returns to IDLE.
- In RUN, blk_ready = (t == 63) & wk_ready & ~flush. This combinational path from wk_ready to blk_ready is intentional.
- Without a handshake (wk_ready = 0), all state holds. wk_data, wk_idx and wk_valid stay stable; wk_valid never drops without a handshake, except on flush or reset.
- flush has priority over everything:
  - The next state is IDLE and t = 0; the window contents are don't-care.
  - Any wk or blk handshake in the flush cycle is ignored, because blk_ready is forced to 0.
  - wk_valid may be high in the flush cycle. The consumer must discard that beat.
- Arithmetic is 32-bit modular; every carry-out is dropped.

## Timing
- While reset is asserted: state = IDLE, t = 0, window = 0, wk_valid = 0, wk_data = 0, wk_idx = 0, wk_last = 0, busy = 0, blk_ready = 0.
- After reset deasserts, blk_ready = 1 in the first cycle.
- Latency: a block accepted in cycle N gives wk_valid = 1 with t = 0 in cycle N+1.
- Throughput: with wk_ready held high, t = 0..63 appear in cycles N+1..N+64. Back-to-back blocks produce no bubble.
- Reset asserted mid-block clears everything asynchronously. No partial block is resumed.
- All outputs are driven from registers through shallow logic, except blk_ready (wk_ready path) and wk_data (one 32-bit adder).

## Configuration
- HERCULESAE_SHA256_KADD_EN defined: wk_data = W[t] + K[t], and the K constant table is instantiated.
- Undefined: wk_data = W[t] only (w[0]), the K table and adder are compiled out, and the round datapath adds K itself.
- All control behaviour and timing are identical in both builds.

## Structure
- Package herculesae_sha256_pkg holds:
  - K[0:63] as a localparam array,
  - the state enum (IDLE, RUN),
  - sigma0_small / sigma1_small as functions,
  - SHA256_ROUNDS = 64 and SHA256_WIN = 16.
- One sub-module: herculesae_vx_sha256_krom, a combinational 6-bit index to 32-bit K lookup. It is instantiated only under HERCULESAE_SHA256_KADD_EN.

## Test plan
- Padded "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), KADD_EN defined, wk_ready = 1. Required words:
  - t = 0: 0xA3EC9318
  - t = 15: 0xC19BF18C
  - t = 16: 0x45FDCD41
  - t = 17: 0xEFCD4786
  - wk_last at t = 63, cycle N+64.
- Same block with KADD_EN undefined: t = 16 gives 0x61626380 and t = 17 gives 0x000F0000. All 64 words match the reference model.
- Random wk_ready stalls (50%): the word sequence is identical to the no-stall run, and wk_data and wk_idx stay stable during every stall.
- Two blocks offered back-to-back with blk_valid held: the second is accepted in the t = 63 handshake cycle, and its t = 0 appears the next cycle with no idle cycle.
- flush asserted at t = 20 with blk_valid = 1 in the same cycle: blk not accepted, IDLE next cycle with wk_valid = 0, and the following block starts at t = 0.
- reset asserted at t = 40 mid-stall: all outputs go to their reset values immediately, and blk_ready = 1 in the first cycle after deassertion.

Source files
------------

// File: rtl/herculesae_sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: round constants, FSM states, small sigmas.
// The K table is consumed only when HERCULESAE_SHA256_KADD_EN is defined.
package herculesae_sha256_pkg;

   localparam int unsigned SHA256_ROUNDS = 64;
   localparam int unsigned SHA256_WIN    = 16;
   localparam int unsigned SHA256_TW     = $clog2(SHA256_ROUNDS);

   localparam logic [31:0] K [SHA256_ROUNDS] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic {StIdle, StRun} state_e;

   function automatic logic [31:0] sigma0_small(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1_small(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/herculesae_vx_sha256_krom.sv
// Combinational SHA-256 round-constant lookup; instantiated only with HERCULESAE_SHA256_KADD_EN.
module herculesae_vx_sha256_krom
   import herculesae_sha256_pkg::*;
(
   input  logic [SHA256_TW-1:0] idx,
   output logic [31:0]          k
);

   assign k = K[idx];

endmodule

// File: rtl/herculesae_vx_sha256_msgsched.sv
// SHA-256 message-schedule engine: loads one 512-bit block, streams W[t](+K[t]) for t = 0..63.
// Define HERCULESAE_SHA256_KADD_EN to add K[t] here instead of in the round datapath.
module herculesae_vx_sha256_msgsched
   import herculesae_sha256_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         flush,
   output logic         wk_valid,
   input  logic         wk_ready,
   output logic [31:0]  wk_data,
   output logic [5:0]   wk_idx,
   output logic         wk_last,
   output logic         busy
);

   state_e                 state_q;
   logic [SHA256_TW-1:0]   t_q;
   logic [31:0]            w_q [SHA256_WIN];

   logic        running;
   logic        last_round;
   logic        wk_hs;
   logic        blk_hs;
   logic [31:0] w_new;

   assign running    = (state_q == StRun);
   assign last_round = (t_q == SHA256_TW'(SHA256_ROUNDS - 1));

   // Next block may enter on the final-round handshake, hence the wk_ready term.
   assign blk_ready = ~reset & ~flush & (~running | (last_round & wk_ready));
   assign blk_hs    = blk_valid & blk_ready;
   assign wk_hs     = running & wk_ready & ~flush;

   assign w_new = sigma1_small(w_q[14]) + w_q[9] + sigma0_small(w_q[1]) + w_q[0];

`ifdef HERCULESAE_SHA256_KADD_EN
   logic [31:0] k_t;

   herculesae_vx_sha256_krom u_krom (
      .idx (t_q),
      .k   (k_t)
   );

   assign wk_data = running ? (w_q[0] + k_t) : 32'h0;
`else
   assign wk_data = running ? w_q[0] : 32'h0;
`endif

   assign wk_valid = running;
   assign wk_idx   = t_q;
   assign wk_last  = running & last_round;
   assign busy     = running;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         t_q     <= '0;
         for (int i = 0; i < SHA256_WIN; i++) w_q[i] <= '0;
      end else if (flush) begin
         state_q <= StIdle;
         t_q     <= '0;
      end else if (blk_hs) begin
         state_q <= StRun;
         t_q     <= '0;
         for (int i = 0; i < SHA256_WIN; i++) w_q[i] <= blk_data[32*i +: 32];
      end else if (wk_hs) begin
         for (int i = 0; i < SHA256_WIN - 1; i++) w_q[i] <= w_q[i+1];
         w_q[SHA256_WIN-1] <= w_new;
         t_q               <= t_q + 1'b1;
         if (last_round) state_q <= StIdle;
      end
   end

endmodule

// File: tb/tb_herculesae_vx_sha256_msgsched.sv
// Scoreboard bench for the SHA-256 message scheduler; follows HERCULESAE_SHA256_KADD_EN.
module tb_herculesae_vx_sha256_msgsched;

   logic         clk = 1'b0;
   logic         reset;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         flush;
   logic         wk_valid;
   logic         wk_ready;
   logic [31:0]  wk_data;
   logic [5:0]   wk_idx;
   logic         wk_last;
   logic         busy;

   herculesae_vx_sha256_msgsched dut (
      .clk       (clk),
      .reset     (reset),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .flush     (flush),
      .wk_valid  (wk_valid),
      .wk_ready  (wk_ready),
      .wk_data   (wk_data),
      .wk_idx    (wk_idx),
      .wk_last   (wk_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low

   typedef struct packed {
      logic [31:0] d;
      logic [5:0]  i;
   } exp_t;
   exp_t exp_q[$];

   logic [31:0] kt [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

`ifdef HERCULESAE_SHA256_KADD_EN
   localparam logic [31:0] AbcT0  = 32'hA3EC9318;
   localparam logic [31:0] AbcT16 = 32'h45FDCD41;
   localparam logic [31:0] AbcT17 = 32'hEFCD4786;
`else
   localparam logic [31:0] AbcT0  = 32'h61626380;
   localparam logic [31:0] AbcT16 = 32'h61626380;
   localparam logic [31:0] AbcT17 = 32'h000F0000;
`endif

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference: textbook W[t] recurrence over a full 64-entry array.
   function automatic void push_block(input logic [511:0] b);
      logic [31:0] w [64];
      logic [31:0] s0, s1;
      exp_t e;
      for (int i = 0; i < 16; i++) w[i] = b[32*i +: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < 64; i++) begin
`ifdef HERCULESAE_SHA256_KADD_EN
         e.d = w[i] + kt[i];
`else
         e.d = w[i];
`endif
         e.i = 6'(i);
         exp_q.push_back(e);
      end
   endfunction

   always @(posedge clk) begin
      cyc++;
      #1;
      case (rdy_mode)
         0:       wk_ready = 1'b1;
         1:       wk_ready = 1'($urandom % 2);
         default: wk_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
   logic        stall_prev = 1'b0;
   logic [31:0] stall_d;
   logic [5:0]  stall_i;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 32'(wk_valid), 32'd1);
            check("stall_data", wk_data, stall_d);
            check("stall_idx", 32'(wk_idx), 32'(stall_i));
         end
         stall_prev = wk_valid & ~wk_ready & ~flush;
         stall_d    = wk_data;
         stall_i    = wk_idx;
         if (wk_valid & wk_ready & ~flush) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got idx %0d, required no beat", wk_idx);
            end else begin
               e = exp_q.pop_front();
               check("wk_data", wk_data, e.d);
               check("wk_idx", 32'(wk_idx), 32'(e.i));
               check("wk_last", 32'(wk_last), 32'(e.i == 6'd63));
            end
         end
      end
   end

   // Call at posedge+2; returns at posedge+2 of the cycle after acceptance.
   task automatic send_block(input logic [511:0] b, output int acc);
      logic got = 1'b0;
      acc       = -1;
      blk_data  = b;
      blk_valid = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (blk_ready) begin
            push_block(b);
            acc = cyc;
            got = 1'b1;
            break;
         end
      end
      if (!got) check("blk_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #2;
      blk_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic idle = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (!busy) begin
            idle = 1'b1;
            break;
         end
      end
      if (!idle) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idx(input logic [5:0] target);
      logic hit = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (wk_valid && wk_idx == target) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check("idx_timeout", 32'(wk_idx), 32'(target));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_blk_ready"}, 32'(blk_ready), 32'd0);
      check({tag, "_wk_valid"}, 32'(wk_valid), 32'd0);
      check({tag, "_wk_data"}, wk_data, 32'd0);
      check({tag, "_wk_idx"}, 32'(wk_idx), 32'd0);
      check({tag, "_wk_last"}, 32'(wk_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   logic [511:0] abc;
   int a0, a1, n;

   initial begin
      abc        = '0;
      abc[31:0]  = 32'h61626380;
      abc[511:480] = 32'h00000018;
      reset      = 1'b1;
      blk_valid  = 1'b0;
      blk_data   = '0;
      flush      = 1'b0;
      wk_ready   = 1'b0;

      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(negedge clk);
      check("blk_ready_after_reset", 32'(blk_ready), 32'd1);

      // abc block with ready held high: latency, known words, wk_last timing.
      @(posedge clk);
      #2;
      send_block(abc, a0);
      @(negedge clk);
      check("abc_first_valid", 32'(wk_valid), 32'd1);
      check("abc_first_idx", 32'(wk_idx), 32'd0);
      check("abc_t0", wk_data, AbcT0);
      n = 1;
      while (!wk_last && n < 100) begin
         @(negedge clk);
         n++;
         if (wk_idx == 6'd16) check("abc_t16", wk_data, AbcT16);
         if (wk_idx == 6'd17) check("abc_t17", wk_data, AbcT17);
      end
      check("abc_last_cycle", 32'(n), 32'd64);
      wait_idle();

      // Back-to-back blocks: second accepted on the t=63 beat, no bubble.
      @(posedge clk);
      #2;
      send_block(rand_block(), a0);
      send_block(rand_block(), a1);
      check("b2b_gap", 32'(a1 - a0), 32'd64);
      @(negedge clk);
      check("b2b_second_valid", 32'(wk_valid), 32'd1);
      check("b2b_second_idx", 32'(wk_idx), 32'd0);
      wait_idle();

      // Random 50% stalls across several blocks.
      rdy_mode = 1;
      @(posedge clk);
      #2;
      send_block(abc, a0);
      send_block(rand_block(), a0);
      send_block(rand_block(), a0);
      wait_idle();
      rdy_mode = 0;

      // Flush at t=20 with a block offered in the same cycle.
      @(posedge clk);
      #2;
      send_block(rand_block(), a0);
      wait_idx(6'd19);
      @(posedge clk);
      #2;
      flush     = 1'b1;
      blk_valid = 1'b1;
      blk_data  = rand_block();
      @(negedge clk);
      check("flush_blk_ready", 32'(blk_ready), 32'd0);
      check("flush_idx", 32'(wk_idx), 32'd20);
      @(posedge clk);
      #2;
      flush     = 1'b0;
      blk_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("post_flush_valid", 32'(wk_valid), 32'd0);
      check("post_flush_busy", 32'(busy), 32'd0);
      check("post_flush_idx", 32'(wk_idx), 32'd0);
      @(posedge clk);
      #2;
      send_block(abc, a0);
      @(negedge clk);
      check("after_flush_idx", 32'(wk_idx), 32'd0);
      check("after_flush_t0", wk_data, AbcT0);
      wait_idle();

      // Reset during a stall at t=40.
      @(posedge clk);
      #2;
      send_block(rand_block(), a0);
      wait_idx(6'd39);
      rdy_mode = 2;
      @(negedge clk);
      check("stall40_idx", 32'(wk_idx), 32'd40);
      @(negedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      @(negedge clk);
      @(posedge clk);
      #3;
      reset    = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      check("blk_ready_after_midreset", 32'(blk_ready), 32'd1);
      check("valid_after_midreset", 32'(wk_valid), 32'd0);

      // One more block to confirm clean restart, then drain.
      @(posedge clk);
      #2;
      send_block(rand_block(), a0);
      wait_idle();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
